uart_rx: RTL
============

Name: uart_rx

Overview:
- Asynchronous serial receiver, the downstream counterpart of the UART transmitter in the same link.
- Recovers frames from RX_IN using oversampling: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
- Delivers a parallel byte with a one-cycle valid strobe, plus parity and stop error flags, to the register/FIFO layer.
- Frame format and parity convention match the transmitter: PAR_TYP=0 even, PAR_TYP=1 odd.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the Prescale input (oversampling ratio).

Ports:
- CLK  input  1  oversampling clock, Prescale × bit rate.
- RST  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line, idle high, asynchronous to CLK.
- Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  input  1  1 = parity bit present between data and stop.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last correctly received byte.
- data_valid  output  1  one-cycle pulse when P_DATA is updated.
- par_err  output  1  one-cycle pulse: parity mismatch on the completed frame.
- stp_err  output  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset (RST=0, asynchronous): FSM → IDLE; counters, shift register and synchronizer cleared to 0 (synchronizer to 1, line-idle). Outputs: P_DATA=0, data_valid=0, par_err=0, stp_err=0.
- RX_IN passes through a 2-flop synchronizer, giving rx_s. All timing below refers to rx_s.
- Configuration latching: on the start-detect cycle, Prescale, PAR_EN and PAR_TYP are latched. Changes mid-frame have no effect on the current frame.
- Counters:
  - edge_cnt counts 0..Prescale-1 within each bit; it wraps to 0 and increments bit_cnt.
  - bit_cnt indexes the bit within the frame.
- Sampling: rx_s is captured at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. The bit value is the majority of the 3 samples and is available at edge_cnt = Prescale/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP, OUT.
  - IDLE: rx_s=0 → START, edge_cnt=0.
  - START: at the end of the bit, if the sampled value is 1 (glitch) → IDLE with no outputs; otherwise → DATA.
  - DATA: the sampled bit shifts in LSB first. After DATA_WIDTH bits → PARITY if the latched PAR_EN=1, else → STOP.
  - PARITY: the sampled bit is compared with XOR(data) ^ PAR_TYP. A mismatch sets an internal par_flag.
  - STOP: the sampled bit is checked. A 0 sets stp_flag. At edge_cnt = Prescale-1 → OUT.
  - OUT (one cycle):
    - If par_flag=0 and stp_flag=0: P_DATA ← shift register, data_valid=1.
    - Otherwise P_DATA is unchanged, data_valid=0, and par_err / stp_err pulse according to their flags (both may pulse together).
    - Flags clear. Next state is START if rx_s=0 in this cycle (back-to-back frame), else IDLE.
- Latency: data_valid rises exactly 1 cycle after the last stop-bit cycle, i.e. (2+DATA_WIDTH+PAR_EN)·Prescale + 1 cycles after start detect, plus 2 synchronizer cycles from RX_IN.
- data_valid, par_err and stp_err are mutually exclusive with respect to data: data_valid=1 implies both error flags are 0.
- Line held low (break): STOP flags stp_err, then the FSM re-enters START on the next frame. This is not a lock-up. Each subsequent frame errors until the line returns high.
- Reset mid-frame: the frame is abandoned with no output pulses and P_DATA=0. After release, reception starts only on a fresh falling edge.
- Illegal Prescale (not 8/16/32): behaviour undefined. The block must not hang; it returns to IDLE within one frame length of Prescale cycles.

Test Plan:
- Prescale=8, PAR_EN=0, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → data_valid pulses once 81 cycles after start detect, P_DATA=0xA5, no errors.
- Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 → P_DATA=0x3C, data_valid=1. Same frame with parity bit 1 → par_err pulse, data_valid=0, P_DATA stays 0x3C.
- Prescale=32, PAR_EN=1, PAR_TYP=1, send 0x01 with stop bit 0 → stp_err pulse only, par_err=0, P_DATA unchanged.
- 3-cycle low glitch on idle line at Prescale=16 → FSM returns to IDLE, no output pulses. A following valid frame 0x5A is received correctly.
- Back-to-back frames 0xFF, 0x00 with no idle gap, Prescale=8 → two data_valid pulses exactly 81 cycles apart, P_DATA=0xFF then 0x00.
- Assert RST low during data bit 4 of frame 0x77 → all outputs 0 immediately. After release, frame 0x12 is received with P_DATA=0x12.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// data_valid / par_err / stp_err are registered pulses that coincide with the one-cycle OUT state.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 3);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  sync_q;
  logic                  rx_s;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] edge_max;
  logic [PRESCALE_W-1:0] half;
  logic [BIT_W-1:0]      bit_cnt;
  logic [2:0]            samples;
  logic                  maj;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_flag;
  logic                  stp_flag;
  logic                  in_frame;
  logic                  start_det;
  logic                  last_edge;
  logic                  avail;

  // A wrapped (illegal) Prescale still produces a bounded count, so the FSM cannot hang.
  assign half      = prescale_q >> 1;
  assign edge_max  = prescale_q - PRESCALE_W'(1);
  assign last_edge = (edge_cnt >= edge_max);
  assign avail     = (edge_cnt == half + PRESCALE_W'(2));
  assign maj       = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);
  assign in_frame  = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);
  // OUT doubles as a start-detect cycle so back-to-back frames need no idle gap.
  assign start_det = ((state == IDLE) || (state == OUT)) && !rx_s;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= RX_IN;
      rx_s   <= sync_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (last_edge) state_nxt = maj ? IDLE : DATA;
      DATA:    if (last_edge && (bit_cnt == BIT_W'(DATA_WIDTH)))
                 state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (last_edge) state_nxt = STOP;
      STOP:    if (last_edge) state_nxt = OUT;
      OUT:     state_nxt = rx_s ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      samples    <= '0;
    end else begin
      if (start_det) begin
        prescale_q <= Prescale;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
      end
      if (in_frame) begin
        if (last_edge) begin
          edge_cnt <= '0;
          bit_cnt  <= bit_cnt + BIT_W'(1);
        end else begin
          edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
        if (edge_cnt == half - PRESCALE_W'(1)) samples[0] <= rx_s;
        if (edge_cnt == half)                  samples[1] <= rx_s;
        if (edge_cnt == half + PRESCALE_W'(1)) samples[2] <= rx_s;
      end else begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q  <= '0;
      par_flag <= 1'b0;
      stp_flag <= 1'b0;
    end else begin
      if ((state == IDLE) || (state == OUT)) begin
        par_flag <= 1'b0;
        stp_flag <= 1'b0;
      end
      if ((state == DATA) && avail)
        shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
      if ((state == PARITY) && avail)
        par_flag <= (maj != (^shift_q ^ par_typ_q));
      if ((state == STOP) && avail && !maj)
        stp_flag <= 1'b1;
    end
  end

  // Pulses are loaded on the last STOP cycle so they are visible during OUT.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if ((state == STOP) && last_edge) begin
        if (!par_flag && !stp_flag) begin
          P_DATA     <= shift_q;
          data_valid <= 1'b1;
        end else begin
          par_err <= par_flag;
          stp_err <= stp_flag;
        end
      end
    end
  end

endmodule
